mux4_reg: RTL and testbench

- Registered 4:1 word multiplexer, parameterised width.
- Selects one of four N-bit data inputs by a 2-bit select. Presents the result on a registered output with clock-enable gating and a valid flag.
- Sits in datapath steering: register-file write-back select and ALU operand select. It is driven by the shared clock generator's CLOCK net.

---
 rtl/mux4_reg.sv | 108 ++++++++++
 tb/tb_mux4_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4_reg.sv
// -----------------------------------------------------------------------------
// mux4_reg: registered 4:1 word multiplexer with clock enable and valid flag.
//
// Each enabled rising CLOCK edge captures D[S] into Y. The same edge also
// captures S into SEL_Q and sets VALID. RESET is synchronous and active-high,
// and it takes priority over ENABLE. When ENABLE is low, all state holds.
//
// Optional build macro: MUX4_REG_PARITY_EN
//   When defined, this adds a PAR output. PAR is the registered XOR reduction
//   of the selected word. It updates on the same edge as Y.
//
// Parameters:
//   N          width of each data input and of Y (must be >= 1)
//   RESET_VAL  value loaded into Y on reset
//
// Ports:
//   CLOCK   in   1  system clock, rising edge
//   RESET   in   1  synchronous active-high reset
//   ENABLE  in   1  clock enable
//   S       in   2  select (00->D0, 01->D1, 10->D2, 11->D3)
//   D0..D3  in   N  data inputs
//   Y       out  N  registered selected data
//   VALID   out  1  Y holds a sample captured since the last reset
//   SEL_Q   out  2  select value that produced the current Y
//   PAR     out  1  registered XOR reduction of Y (MUX4_REG_PARITY_EN only)
// -----------------------------------------------------------------------------
module mux4_reg #(
    parameter int unsigned N         = 32,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         ENABLE,
    input  logic [1:0]   S,
    input  logic [N-1:0] D0,
    input  logic [N-1:0] D1,
    input  logic [N-1:0] D2,
    input  logic [N-1:0] D3,
    output logic [N-1:0] Y,
    output logic         VALID,
`ifdef MUX4_REG_PARITY_EN
    output logic [1:0]   SEL_Q,
    output logic         PAR
`else
    output logic [1:0]   SEL_Q
`endif
);

    localparam int unsigned SEL_W = 2;

    logic [N-1:0]     y_q,   y_d;
    logic             vld_q, vld_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     mux_c;

    // Nested conditionals let an X/Z select propagate X into the result in
    // simulation, rather than being coerced to one particular input.
    assign mux_c = S[1] ? (S[0] ? D3 : D2) : (S[0] ? D1 : D0);

`ifdef MUX4_REG_PARITY_EN
    logic par_q, par_d;
`endif

    // Next-state: hold by default, capture when enabled
    always_comb begin
        y_d   = y_q;
        vld_d = vld_q;
        sel_d = sel_q;
`ifdef MUX4_REG_PARITY_EN
        par_d = par_q;
`endif
        if (ENABLE) begin
            y_d   = mux_c;
            vld_d = 1'b1;
            sel_d = S;
`ifdef MUX4_REG_PARITY_EN
            par_d = ^mux_c;
`endif
        end
    end

    // State registers with synchronous reset (reset wins over enable)
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            y_q   <= RESET_VAL;
            vld_q <= 1'b0;
            sel_q <= SEL_W'(0);
`ifdef MUX4_REG_PARITY_EN
            par_q <= ^RESET_VAL;
`endif
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
            sel_q <= sel_d;
`ifdef MUX4_REG_PARITY_EN
            par_q <= par_d;
`endif
        end
    end

    assign Y     = y_q;
    assign VALID = vld_q;
    assign SEL_Q = sel_q;
`ifdef MUX4_REG_PARITY_EN
    assign PAR   = par_q;
`endif

endmodule

// File: tb/tb_mux4_reg.sv
// -----------------------------------------------------------------------------
// tb_mux4_reg: self-checking bench for mux4_reg (N=32, RESET_VAL=0).
// Stimulus is driven on the falling edge. A reference model pushes the
// expected post-edge state into a queue. Each test pops the expected state
// after the rising edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mux4_reg;

    localparam int unsigned N = 32;

    typedef struct packed {
        logic [N-1:0] y;
        logic         v;
        logic [1:0]   s;
        logic         p;
    } obs_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   s;
    logic [N-1:0] d0, d1, d2, d3;
    logic [N-1:0] y;
    logic         valid;
    logic [1:0]   sel_q;
    logic         par;

    int unsigned total = 0;
    int unsigned bad   = 0;

    obs_t sb[$];
    obs_t m;      // reference model state
    obs_t exp_v;
    obs_t obs_v;

    mux4_reg #(.N(N), .RESET_VAL('0)) dut (
        .CLOCK  (clk),
        .RESET  (rst),
        .ENABLE (en),
        .S      (s),
        .D0     (d0),
        .D1     (d1),
        .D2     (d2),
        .D3     (d3),
        .Y      (y),
        .VALID  (valid),
`ifdef MUX4_REG_PARITY_EN
        .SEL_Q  (sel_q),
        .PAR    (par)
`else
        .SEL_Q  (sel_q)
`endif
    );

`ifndef MUX4_REG_PARITY_EN
    assign par = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model, and queue its result
    task automatic drive(input logic r, input logic e, input logic [1:0] sv,
                         input logic [N-1:0] a0, input logic [N-1:0] a1,
                         input logic [N-1:0] a2, input logic [N-1:0] a3);
        logic [N-1:0] pick;
        @(negedge clk);
        rst = r; en = e; s = sv; d0 = a0; d1 = a1; d2 = a2; d3 = a3;
        case (sv)
            2'd0:    pick = a0;
            2'd1:    pick = a1;
            2'd2:    pick = a2;
            default: pick = a3;
        endcase
        if (r) begin
            m.y = '0; m.v = 1'b0; m.s = 2'd0; m.p = 1'b0;
        end else if (e) begin
            m.y = pick; m.v = 1'b1; m.s = sv;
`ifdef MUX4_REG_PARITY_EN
            m.p = ^pick;
`else
            m.p = 1'b0;
`endif
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 2'd3, 32'h1, 32'h2, 32'h3, 32'h5);
            exp_v = sb.pop_front();
            obs_v = '{y: y, v: valid, s: sel_q, p: par};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL reset[%0d]: got y=%h v=%b s=%b p=%b, want y=%h v=%b s=%b p=%b",
                         i, obs_v.y, obs_v.v, obs_v.s, obs_v.p, exp_v.y, exp_v.v, exp_v.s, exp_v.p);
            end
        end
    endtask

    task automatic test_disabled_after_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'd3, 32'h1, 32'h2, 32'h3, 32'h5);
            exp_v = sb.pop_front();
            obs_v = '{y: y, v: valid, s: sel_q, p: par};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL disabled[%0d]: got y=%h v=%b s=%b p=%b, want y=%h v=%b s=%b p=%b",
                         i, obs_v.y, obs_v.v, obs_v.s, obs_v.p, exp_v.y, exp_v.v, exp_v.s, exp_v.p);
            end
        end
    endtask

    task automatic test_each_select();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), 32'h1, 32'h2, 32'h3, 32'h5);
            exp_v = sb.pop_front();
            obs_v = '{y: y, v: valid, s: sel_q, p: par};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL select[%0d]: got y=%h v=%b s=%b p=%b, want y=%h v=%b s=%b p=%b",
                         i, obs_v.y, obs_v.v, obs_v.s, obs_v.p, exp_v.y, exp_v.v, exp_v.s, exp_v.p);
            end
        end
    endtask

    task automatic test_hold();
        // Y is 0x5 with S=11 going in; disabled changes must not take effect
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b0, 1'b0, 2'd0, 32'h1, 32'h2, 32'h3, 32'hDEADBEEF);
            else       drive(1'b0, 1'b1, 2'd0, 32'h1, 32'h2, 32'h3, 32'hDEADBEEF);
            exp_v = sb.pop_front();
            obs_v = '{y: y, v: valid, s: sel_q, p: par};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL hold[%0d]: got y=%h v=%b s=%b p=%b, want y=%h v=%b s=%b p=%b",
                         i, obs_v.y, obs_v.v, obs_v.s, obs_v.p, exp_v.y, exp_v.v, exp_v.s, exp_v.p);
            end
        end
    endtask

    task automatic test_reset_priority();
        for (int i = 0; i < 2; i++) begin
            drive((i == 0), 1'b1, 2'd3, 32'h1, 32'h2, 32'h3, 32'h5);
            exp_v = sb.pop_front();
            obs_v = '{y: y, v: valid, s: sel_q, p: par};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL rst_prio[%0d]: got y=%h v=%b s=%b p=%b, want y=%h v=%b s=%b p=%b",
                         i, obs_v.y, obs_v.v, obs_v.s, obs_v.p, exp_v.y, exp_v.v, exp_v.s, exp_v.p);
            end
        end
    endtask

    task automatic test_parity();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? 2'd2 : 2'd3, 32'h1, 32'h2, 32'h3, 32'h7);
            exp_v = sb.pop_front();
            obs_v = '{y: y, v: valid, s: sel_q, p: par};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL parity[%0d]: got y=%h v=%b s=%b p=%b, want y=%h v=%b s=%b p=%b",
                         i, obs_v.y, obs_v.v, obs_v.s, obs_v.p, exp_v.y, exp_v.v, exp_v.s, exp_v.p);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
            exp_v = sb.pop_front();
            obs_v = '{y: y, v: valid, s: sel_q, p: par};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL b2b[%0d]: got y=%h v=%b s=%b p=%b, want y=%h v=%b s=%b p=%b",
                         i, obs_v.y, obs_v.v, obs_v.s, obs_v.p, exp_v.y, exp_v.v, exp_v.s, exp_v.p);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s = 2'd0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        m  = '0;
        test_reset();
        test_disabled_after_reset();
        test_each_select();
        test_hold();
        test_reset_priority();
        test_parity();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
